// File: rtl/toy_mem_req_adapter.sv
// Request-side front end for the toy single-port memory: registers requests onto the
// memory strobe interface and returns read data in order through a credit-checked FIFO.
module toy_mem_req_adapter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy
);

  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  logic                  mem_en_q, mem_en_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [1:0]            rd_pipe_q, rd_pipe_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];

  logic             accept;
  logic             issue_rd;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] outstanding;

  // A read stays counted from acceptance until its response is popped; once the data
  // lands in the FIFO it is carried by count_q, so rd_pipe_q[1] is not counted again.
  assign issue_rd    = mem_en_q & ~mem_wr_en_q;
  assign outstanding = CNT_W'(issue_rd) + CNT_W'(rd_pipe_q[0]) + count_q;
  assign req_rdy     = rst_n && (req_wr || (outstanding < DEPTH_C));
  assign accept      = req_vld && req_rdy;
  assign push        = rd_pipe_q[0];
  assign pop         = rsp_vld && rsp_rdy;

  always_comb begin
    mem_en_d      = accept;
    mem_wr_en_d   = accept && req_wr;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    if (accept) begin
      mem_addr_d    = req_addr;
      mem_wr_data_d = req_wdata;
    end
  end

  always_comb begin
    rd_pipe_d = {rd_pipe_q[0], issue_rd};
    wr_ptr_d  = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d  = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q      <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rd_pipe_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      mem_en_q      <= mem_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rd_pipe_q     <= rd_pipe_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= mem_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !pop) begin
      assert (count_q != DEPTH_C);
    end
  end

  assign rsp_vld     = (count_q != '0);
  assign rsp_rdata   = fifo_q[rd_ptr_q];
  assign mem_en      = mem_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign busy        = (|rd_pipe_q) | issue_rd | (count_q != '0);

endmodule

// File: tb/tb_toy_mem_req_adapter.sv
// Bench for toy_mem_req_adapter: directed and random traffic against a transaction-level
// model (shadow memory + in-order response queue + credit count).
module tb_toy_mem_req_adapter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_vld = 1'b0;
  logic          req_rdy;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_vld;
  logic          rsp_rdy = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          mem_en;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic          busy;

  always #5 clk = ~clk;

  toy_mem_req_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
  );

  // Toy single-port memory with registered read data.
  logic [DW-1:0] mem_arr [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) mem_arr[mem_addr[5:0]] <= mem_wr_data;
      else           mem_rd_data <= mem_arr[mem_addr[5:0]];
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Transaction-level reference state.
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] exp_q [$];
  int            edge_q [$];
  logic [DW-1:0] got_q [$];
  int            n_out = 0;
  int            cyc = 0;
  bit [2:0]      rd_hist = '0;
  bit            acc_last = 1'b0;
  bit            wr_last = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wd = '0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    edge_q.delete();
    n_out     = 0;
    rd_hist   = '0;
    acc_last  = 1'b0;
    wr_last   = 1'b0;
    last_addr = '0;
    last_wd   = '0;
  endtask

  // One clock cycle: drive, check mid-cycle against the model, advance model at the edge.
  task automatic cycle(input bit vld, input bit wr, input logic [5:0] a,
                       input logic [DW-1:0] wd, input bit rr, output bit acc);
    bit exp_rdy, exp_vld, pop;
    req_vld   = vld;
    req_wr    = wr;
    req_addr  = {26'd0, a};
    req_wdata = wd;
    rsp_rdy   = rr;
    #4;
    exp_rdy = wr || (n_out < DEPTH);
    exp_vld = (edge_q.size() > 0) && (edge_q[0] <= cyc - 2);
    chk1("req_rdy", req_rdy, exp_rdy);
    chk1("rsp_vld", rsp_vld, exp_vld);
    if (exp_vld) chk32("rsp_rdata", rsp_rdata, exp_q[0]);
    chk1("mem_en", mem_en, acc_last);
    chk1("mem_wr_en", mem_wr_en, acc_last && wr_last);
    chk32("mem_addr", mem_addr, last_addr);
    chk32("mem_wr_data", mem_wr_data, last_wd);
    chk1("busy", busy, (n_out != 0) || rd_hist[2]);
    acc = vld && exp_rdy;
    pop = exp_vld && rr;
    if (pop) got_q.push_back(rsp_rdata);
    @(posedge clk);
    cyc++;
    if (pop) begin
      void'(exp_q.pop_front());
      void'(edge_q.pop_front());
      n_out--;
    end
    if (acc) begin
      last_addr = {26'd0, a};
      last_wd   = wd;
      if (wr) ref_mem[a] = wd;
      else begin
        exp_q.push_back(ref_mem[a]);
        edge_q.push_back(cyc);
        n_out++;
      end
    end
    acc_last = acc;
    wr_last  = wr;
    rd_hist  = {rd_hist[1:0], acc && !wr};
    #1;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 20 && (exp_q.size() > 0 || rd_hist != 0); i++) begin
      cycle(1'b0, 1'b0, 6'd0, '0, 1'b1, acc);
    end
    chk32("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    int na;
    logic [DW-1:0] d;

    // Reset state, with req_wr high to show rst_n gates req_rdy.
    req_wr = 1'b1;
    #1;
    chk1("rst_req_rdy", req_rdy, 1'b0);
    chk1("rst_rsp_vld", rsp_vld, 1'b0);
    chk32("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_wr_en", mem_wr_en, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'd0);
    chk32("rst_mem_wr_data", mem_wr_data, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    req_wr = 1'b0;
    @(posedge clk); #4; rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;

    // Single write then read of 0x10.
    cycle(1'b1, 1'b1, 6'h10, 32'hDEADBEEF, 1'b1, acc);
    chk1("t1_wr_acc", acc, 1'b1);
    cycle(1'b1, 1'b0, 6'h10, 32'h0, 1'b1, acc);
    chk1("t1_rd_acc", acc, 1'b1);
    drain();
    chk32("t1_rdata", got_q[got_q.size()-1], 32'hDEADBEEF);

    // Preload every address with random data through the adapter.
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 1'b1, 6'(i), $urandom, 1'b1, acc);
    end

    // Eight back-to-back reads of distinct addresses.
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 6'(i * 3 + 1), '0, 1'b1, acc);
      chk1("b2b_acc", acc, 1'b1);
    end
    drain();
    chk32("b2b_count", 32'(got_q.size()), 32'd8);

    // Credit exhaustion with rsp_rdy low.
    na = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 6'(20 + na), '0, 1'b0, acc);
      if (acc) na++;
    end
    chk32("credit_acc", 32'(na), 32'd4);
    cycle(1'b1, 1'b1, 6'd40, 32'hA5A5_0001, 1'b0, acc);
    chk1("credit_wr_acc", acc, 1'b1);
    for (int i = 0; i < 20 && na < 6; i++) begin
      cycle(1'b1, 1'b0, 6'(20 + na), '0, 1'b1, acc);
      if (acc) na++;
    end
    chk32("credit_total", 32'(na), 32'd6);
    drain();

    // Alternating write/read to one address.
    got_q.delete();
    cycle(1'b1, 1'b1, 6'd9, 32'h1, 1'b1, acc);
    cycle(1'b1, 1'b0, 6'd9, 32'h0, 1'b1, acc);
    cycle(1'b1, 1'b1, 6'd9, 32'h2, 1'b1, acc);
    cycle(1'b1, 1'b0, 6'd9, 32'h0, 1'b1, acc);
    drain();
    chk32("raw_cnt", 32'(got_q.size()), 32'd2);
    chk32("raw_r0", got_q[0], 32'h1);
    chk32("raw_r1", got_q[1], 32'h2);

    // Fill FIFO to DEPTH-1, then stream with simultaneous push/pop across pointer wrap.
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 1'b0, 6'(i + 30), '0, 1'b0, acc);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 6'd0, '0, 1'b0, acc);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cycle(1'b1, 1'b0, 6'(i + 2), '0, 1'b1, acc);
      chk1("wrap_acc", acc, 1'b1);
    end
    drain();

    // Random traffic.
    for (int i = 0; i < 120; i++) begin
      d = $urandom;
      cycle(($urandom % 4) != 0, ($urandom % 3) == 0, 6'($urandom % 64), d,
            ($urandom % 4) != 0, acc);
    end
    drain();

    // Reset with three reads outstanding.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 6'(i + 50), '0, 1'b0, acc);
    req_vld = 1'b1;
    req_wr  = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk1("mid_rst_req_rdy", req_rdy, 1'b0);
    chk1("mid_rst_rsp_vld", rsp_vld, 1'b0);
    chk32("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    chk1("mid_rst_mem_en", mem_en, 1'b0);
    chk1("mid_rst_mem_wr_en", mem_wr_en, 1'b0);
    chk32("mid_rst_mem_addr", mem_addr, 32'd0);
    chk32("mid_rst_mem_wr_data", mem_wr_data, 32'd0);
    chk1("mid_rst_busy", busy, 1'b0);
    req_vld = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #4; rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 6'd0, '0, 1'b1, acc);
    got_q.delete();
    cycle(1'b1, 1'b0, 6'h10, '0, 1'b1, acc);
    chk1("post_rst_acc", acc, 1'b1);
    drain();
    chk32("post_rst_cnt", 32'(got_q.size()), 32'd1);
    chk32("post_rst_rdata", got_q[0], ref_mem[16]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
